// File: rtl/doodle_pkg.sv
// Shared jump-state encoding and screen geometry for the doodle game blocks.
package doodle_pkg;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2,
        ST_DONE = 2'd3
    } jump_state_e;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // One-hot LED pattern ordered {q_I, q_Up, q_Down, q_Done}.
    function automatic logic [3:0] state_flags(jump_state_e s);
        return 4'b1000 >> s;
    endfunction

endpackage

// File: rtl/doodle_motion_ctrl_if.sv
// Player-input, collision and renderer-facing signals of the doodle motion controller.
interface doodle_motion_ctrl_if;
    logic       start;
    logic       tilt_left;
    logic       tilt_right;
    logic [3:0] tilt_intensity;
    logic       land_hit;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic       scroll_req;
    logic [4:0] scroll_amt;
    logic [7:0] score;
    logic       q_I;
    logic       q_Up;
    logic       q_Down;
    logic       q_Done;

    modport master (
        output start, tilt_left, tilt_right, tilt_intensity, land_hit,
        input  xpos, ypos, scroll_req, scroll_amt, score, q_I, q_Up, q_Down, q_Done
    );

    modport slave (
        input  start, tilt_left, tilt_right, tilt_intensity, land_hit,
        output xpos, ypos, scroll_req, scroll_amt, score, q_I, q_Up, q_Down, q_Done
    );
endinterface

// File: rtl/doodle_motion_ctrl_tick_gen.sv
// Free-running physics tick: one-cycle enable every TICK_DIV clocks.
module tick_gen #(
    parameter int TICK_DIV = 524288
) (
    input  logic ClkPort,
    input  logic Reset,
    output logic tick
);
    logic [19:0] cnt_q;

    assign tick = (cnt_q == 20'(TICK_DIV - 1));

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 20'd1;
        end
    end
endmodule

// File: rtl/doodle_motion_ctrl.sv
// Doodle jump sequencer: vertical physics, tilt steering with wrap, scroll requests and score.
module doodle_motion_ctrl
    import doodle_pkg::*;
#(
    parameter int TICK_DIV    = 524288,
    parameter int X_START     = 320,
    parameter int Y_START     = 400,
    parameter int JUMP_V      = 8,
    parameter int MAX_V       = 12,
    parameter int SCROLL_LINE = 200,
    parameter int FLOOR_Y     = doodle_pkg::SCREEN_H - 1,
    parameter int SCREEN_W    = doodle_pkg::SCREEN_W
) (
    input logic                 ClkPort,
    input logic                 Reset,
    doodle_motion_ctrl_if.slave bus
);
    localparam logic signed [10:0] SCROLL_S = 11'(SCROLL_LINE);

    jump_state_e state_q;
    logic [3:0]  flags_q;
    logic [9:0]  xpos_q, ypos_q;
    logic [4:0]  vel_q;
    logic [7:0]  score_q;
    logic        scroll_req_q;
    logic [4:0]  scroll_amt_q;
    logic        tick;

    logic signed [10:0] up_ny_d;
    logic               up_scroll_d;
    logic [4:0]         up_amt_d;
    logic [5:0]         vel_inc_d;
    logic [4:0]         dn_nv_d;
    logic [10:0]        dn_ny_d;
    logic               dn_floor_d;
    logic [10:0]        x_sum_d;
    logic [9:0]         xpos_d;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .ClkPort (ClkPort),
        .Reset   (Reset),
        .tick    (tick)
    );

    // NOTE: every combinational output gets a default first so no latch can be inferred.
    always_comb begin
        up_ny_d     = $signed({1'b0, ypos_q}) - $signed({6'b0, vel_q});
        up_scroll_d = up_ny_d < SCROLL_S;
        up_amt_d    = 5'(SCROLL_S - up_ny_d);
        vel_inc_d   = {1'b0, vel_q} + 6'd1;
        dn_nv_d     = (vel_inc_d > 6'(MAX_V)) ? 5'(MAX_V) : vel_inc_d[4:0];
        dn_ny_d     = {1'b0, ypos_q} + {6'b0, dn_nv_d};
        dn_floor_d  = dn_ny_d >= 11'(FLOOR_Y);
        x_sum_d     = {1'b0, xpos_q} + {7'b0, bus.tilt_intensity};
        xpos_d      = xpos_q;
        if (bus.tilt_right && !bus.tilt_left) begin
            xpos_d = (x_sum_d >= 11'(SCREEN_W)) ? 10'(x_sum_d - 11'(SCREEN_W)) : x_sum_d[9:0];
        end else if (bus.tilt_left && !bus.tilt_right) begin
            xpos_d = (xpos_q < {6'b0, bus.tilt_intensity})
                   ? 10'({1'b0, xpos_q} + 11'(SCREEN_W) - {7'b0, bus.tilt_intensity})
                   : xpos_q - {6'b0, bus.tilt_intensity};
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_INIT;
            flags_q      <= state_flags(ST_INIT);
            xpos_q       <= 10'(X_START);
            ypos_q       <= 10'(Y_START);
            vel_q        <= '0;
            score_q      <= '0;
            scroll_req_q <= 1'b0;
            scroll_amt_q <= '0;
        end else begin
            scroll_req_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    xpos_q <= 10'(X_START);
                    ypos_q <= 10'(Y_START);
                    vel_q  <= '0;
                    if (bus.start) begin
                        state_q <= ST_UP;
                        flags_q <= state_flags(ST_UP);
                        vel_q   <= 5'(JUMP_V);
                        score_q <= '0;
                    end
                end
                ST_UP: if (tick) begin
                    xpos_q <= xpos_d;
                    // Rising past the scroll line moves the world instead of the doodle.
                    if (up_scroll_d) begin
                        ypos_q       <= 10'(SCROLL_LINE);
                        scroll_amt_q <= up_amt_d;
                        scroll_req_q <= 1'b1;
                    end else begin
                        ypos_q <= up_ny_d[9:0];
                    end
                    vel_q <= vel_q - 5'd1;
                    if (vel_q == 5'd1) begin
                        state_q <= ST_DOWN;
                        flags_q <= state_flags(ST_DOWN);
                    end
                end
                ST_DOWN: if (tick) begin
                    xpos_q <= xpos_d;
                    if (bus.land_hit) begin
                        state_q <= ST_UP;
                        flags_q <= state_flags(ST_UP);
                        vel_q   <= 5'(JUMP_V);
                        if (score_q != 8'hFF) score_q <= score_q + 8'd1;
                    end else if (dn_floor_d) begin
                        ypos_q  <= 10'(FLOOR_Y);
                        state_q <= ST_DONE;
                        flags_q <= state_flags(ST_DONE);
                    end else begin
                        ypos_q <= dn_ny_d[9:0];
                        vel_q  <= dn_nv_d;
                    end
                end
                ST_DONE: if (bus.start) begin
                    state_q <= ST_INIT;
                    flags_q <= state_flags(ST_INIT);
                end
            endcase
        end
    end

    assign bus.xpos       = xpos_q;
    assign bus.ypos       = ypos_q;
    assign bus.scroll_req = scroll_req_q;
    assign bus.scroll_amt = scroll_amt_q;
    assign bus.score      = score_q;
    assign bus.q_I        = flags_q[3];
    assign bus.q_Up       = flags_q[2];
    assign bus.q_Down     = flags_q[1];
    assign bus.q_Done     = flags_q[0];
endmodule
